// File: rtl/lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// lcd_bus_driver
//
// Write-only byte driver for an HD44780-style character LCD bus. A one-cycle
// start request latches data/irs onto lcd_data/lcd_rs. The driver then waits
// SETUP_CYC cycles and drives an EN strobe that is high for EN_HIGH_CYC
// cycles. It holds the bus for HOLD_CYC cycles and finally pulses done for
// one cycle.
//
// Optional feature (macro LCD_BUSY_WAIT_EN):
//   When defined, an execution wait follows the hold phase. The wait lasts
//   LONG_EXEC_CYC cycles for the clear (8'h01) and home (8'h02) commands, and
//   EXEC_CYC cycles for every other byte. When undefined, the hold phase goes
//   straight to done and the upstream sequencer supplies the inter-command
//   delay.
//
// Ports:
//   clk       in   rising-edge system clock
//   rst       in   synchronous, active-low reset
//   data      in   [7:0] byte to write
//   irs       in   register select for the byte (0 command, 1 character)
//   start     in   one-cycle write request, honoured only while idle
//   done      out  one-cycle pulse when the write completes
//   lcd_data  out  [7:0] LCD data bus
//   lcd_rw    out  LCD read/write, tied to 0 (write only)
//   lcd_en    out  LCD enable strobe (registered)
//   lcd_rs    out  LCD register select
//   lcd_on    out  LCD power enable, set from the first clock out of reset
// -----------------------------------------------------------------------------
module lcd_bus_driver #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_HIGH_CYC   = 16,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2500,
    parameter int LONG_EXEC_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       irs,
    input  logic       start,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_on
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // The shared counter is loaded with (duration - 1) on entry to a timed
    // state. The state exits in the cycle where the counter reads zero.
    // Seventeen bits cover every duration up to 131071 without wrapping.
    localparam logic [16:0] SETUP_LOAD     = 17'(SETUP_CYC - 1);
    localparam logic [16:0] PULSE_LOAD     = 17'(EN_HIGH_CYC - 1);
    localparam logic [16:0] HOLD_LOAD      = 17'(HOLD_CYC - 1);
    localparam logic [16:0] EXEC_LOAD      = 17'(EXEC_CYC - 1);
    localparam logic [16:0] LONG_EXEC_LOAD = 17'(LONG_EXEC_CYC - 1);

    logic [2:0]  state_reg, state_next;
    logic [16:0] cnt_reg, cnt_next;
    logic [7:0]  data_reg, data_next;
    logic        rs_reg, rs_next;
    logic        en_reg, en_next;
    logic        done_reg, done_next;
    logic        on_reg;
    logic        cnt_expired;
    logic        long_cmd;

    assign cnt_expired = (cnt_reg == 17'd0);

    // Clear display and return home need the long execution time.
    assign long_cmd = !rs_reg && ((data_reg == 8'h01) || (data_reg == 8'h02));

    // Next-state and bus-latch logic.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        rs_next    = rs_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                    data_next  = data;
                    rs_next    = irs;
                end
            end
            S_SETUP: begin
                if (cnt_expired) begin
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_expired) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_expired) begin
`ifdef LCD_BUSY_WAIT_EN
                    state_next = S_EXEC;
`else
                    state_next = S_DONE;
`endif
                end
            end
            S_EXEC: begin
                if (cnt_expired) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start seen in this cycle is dropped; the next request
                // is taken from the following idle cycle.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counter: reload on every state change with the length of the state
    // being entered. Otherwise count down to zero and hold there.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg) begin
            case (state_next)
                S_SETUP: cnt_next = SETUP_LOAD;
                S_PULSE: cnt_next = PULSE_LOAD;
                S_HOLD:  cnt_next = HOLD_LOAD;
                S_EXEC:  cnt_next = long_cmd ? LONG_EXEC_LOAD : EXEC_LOAD;
                default: cnt_next = 17'd0;
            endcase
        end else if (!cnt_expired) begin
            cnt_next = cnt_reg - 17'd1;
        end
    end

    // EN and done are decoded from the next state and then registered. This
    // keeps both outputs glitch-free and aligned with the state they mark.
    always_comb begin
        en_next   = (state_next == S_PULSE);
        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 17'd0;
            data_reg  <= 8'h00;
            rs_reg    <= 1'b0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
            on_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            rs_reg    <= rs_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
            on_reg    <= 1'b1;
        end
    end

    assign done     = done_reg;
    assign lcd_data = data_reg;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_reg;
    assign lcd_rs   = rs_reg;
    assign lcd_on   = on_reg;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_driver
//
// Bench for lcd_bus_driver with default parameters. A transaction-timeline
// model tracks, for each accepted request, the number of cycles elapsed since
// the latch edge. The expected bus state follows from the phase lengths:
//   EN high for elapsed cycles SETUP+1 .. SETUP+EN_HIGH
//   done at elapsed cycle SETUP+EN_HIGH+HOLD+1 (plus execution wait)
// A negedge process compares every output with the model on every cycle.
// Directed transfers pin the model against hand-computed latencies.
// Randomized traffic follows the directed transfers.
// -----------------------------------------------------------------------------
module tb_lcd_bus_driver;

    localparam int S  = 2;
    localparam int EN = 16;
    localparam int H  = 2;
`ifdef LCD_BUSY_WAIT_EN
    localparam int EX  = 2500;
    localparam int LEX = 82000;
    localparam int LAT_NORMAL = 2521;
`else
    localparam int LAT_NORMAL = 21;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       irs;
    logic       start;
    logic       done;
    logic [7:0] lcd_data;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_on;

    lcd_bus_driver dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .irs      (irs),
        .start    (start),
        .done     (done),
        .lcd_data (lcd_data),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_on   (lcd_on)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

`ifdef LCD_BUSY_WAIT_EN
    function automatic int exec_len(input logic [7:0] d, input logic r);
        return (!r && (d == 8'h01 || d == 8'h02)) ? LEX : EX;
    endfunction
`endif

    // ---------------- behavioural timeline model ----------------
    bit         model_valid = 1'b0;
    bit         busy = 1'b0;
    int         t = 0;
    int         done_k = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0;
    logic       m_on = 1'b0;

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (!rst) begin
            busy   <= 1'b0;
            t      <= 0;
            m_data <= 8'h00;
            m_rs   <= 1'b0;
            m_on   <= 1'b0;
        end else begin
            m_on <= 1'b1;
            if (busy) begin
                if (t == done_k) busy <= 1'b0;
                else t <= t + 1;
            end else if (start) begin
                busy   <= 1'b1;
                t      <= 1;
                m_data <= data;
                m_rs   <= irs;
`ifdef LCD_BUSY_WAIT_EN
                done_k <= S + EN + H + 1 + exec_len(data, irs);
`else
                done_k <= S + EN + H + 1;
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            check("lcd_en",   lcd_en,   busy && (t >= S + 1) && (t <= S + EN));
            check("done",     done,     busy && (t == done_k));
            check("lcd_data", lcd_data, m_data);
            check("lcd_rs",   lcd_rs,   m_rs);
            check("lcd_on",   lcd_on,   m_on);
            check("lcd_rw",   lcd_rw,   1'b0);
        end
    end

    // ---------------- directed transfer ----------------
    // mode 0: stop at done; mode 1: re-pulse start mid-transfer and keep
    // watching; mode 2: reset during the EN pulse.
    task automatic xfer(input logic [7:0] d, input logic r, input int mode,
                        output int lat, output int en_first, output int en_hi,
                        output int en_rise, output int done_cnt);
        int   c0;
        int   w;
        logic en_prev;
        lat = -1; en_first = -1; en_hi = 0; en_rise = 0; done_cnt = 0; en_prev = 1'b0;
        @(posedge clk); #2;
        data = d; irs = r; start = 1'b1; c0 = cyc;
        @(posedge clk); #2;
        start = 1'b0; data = 8'hAA; irs = ~r;
        w = LAT_NORMAL + 30;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (mode == 1) start = (cyc == c0 + 5) || (cyc == c0 + 10);
            if (mode == 2 && cyc == c0 + 8) begin
                check("pre_rst_en", lcd_en, 1'b1);
                rst = 1'b0;
            end
            if (mode == 2 && cyc == c0 + 9) begin
                rst = 1'b1;
                check("rst_en",   lcd_en,   1'b0);
                check("rst_data", lcd_data, 8'h00);
                check("rst_on",   lcd_on,   1'b0);
                check("rst_done", done,     1'b0);
            end
            if (lcd_en === 1'b1) begin
                en_hi++;
                if (!en_prev) begin
                    en_rise++;
                    if (en_first < 0) en_first = cyc - c0;
                end
            end
            en_prev = lcd_en;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) lat = cyc - c0;
                if (mode == 0) break;
            end
        end
        start = 1'b0;
    endtask

    int lat, en_first, en_hi, en_rise, done_cnt;

    initial begin
        rst = 1'b0; start = 1'b0; data = 8'h00; irs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_on",   lcd_on,   1'b0);
        check("reset_data", lcd_data, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Command 0x38: strobe timing and latency.
        xfer(8'h38, 1'b0, 0, lat, en_first, en_hi, en_rise, done_cnt);
        check("cmd38_latency",  lat,      LAT_NORMAL);
        check("cmd38_en_start", en_first, 3);
        check("cmd38_en_len",   en_hi,    16);
        check("cmd38_data",     lcd_data, 8'h38);

        // Character 0x41: register select high.
        xfer(8'h41, 1'b1, 0, lat, en_first, en_hi, en_rise, done_cnt);
        check("char41_latency", lat,    LAT_NORMAL);
        check("char41_rs",      lcd_rs, 1'b1);

        // Start re-pulsed mid-transfer is ignored.
        xfer(8'h55, 1'b0, 1, lat, en_first, en_hi, en_rise, done_cnt);
        check("repulse_en_pulses", en_rise,  1);
        check("repulse_dones",     done_cnt, 1);
        check("repulse_data",      lcd_data, 8'h55);

        // Reset during the EN pulse aborts the transfer, then 0x0C runs normally.
        xfer(8'h21, 1'b0, 2, lat, en_first, en_hi, en_rise, done_cnt);
        check("abort_dones", done_cnt, 0);
        xfer(8'h0C, 1'b0, 0, lat, en_first, en_hi, en_rise, done_cnt);
        check("cmd0c_latency", lat, LAT_NORMAL);

        // Back-to-back: second start in the idle cycle right after done.
        xfer(8'h48, 1'b1, 0, lat, en_first, en_hi, en_rise, done_cnt);
        check("b2b_first_latency", lat, LAT_NORMAL);
        check("b2b_first_dones",   done_cnt, 1);
        xfer(8'h49, 1'b1, 0, lat, en_first, en_hi, en_rise, done_cnt);
        check("b2b_second_latency", lat, LAT_NORMAL);
        check("b2b_second_dones",   done_cnt, 1);
        check("b2b_second_data",    lcd_data, 8'h49);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst   = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 3) == 0);
            data  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            irs   = 1'($urandom);
        end
        @(posedge clk); #2;
        start = 1'b0; rst = 1'b1;
        repeat (LAT_NORMAL + 10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
